// File: rtl/frame_ctrl_pkg.sv
// frame_ctrl_pkg: shared FSM state type and frame-geometry helpers for frame_stream_ctrl
// Contents: state_t (IDLE, STREAM, FLUSH, DRAIN, DONE); radius(), pix_total(), flush_len()
package frame_ctrl_pkg;
   typedef enum logic [2:0] {IDLE, STREAM, FLUSH, DRAIN, DONE} state_t;
   function automatic int radius(input int filt_width);
      return filt_width / 2;
   endfunction
   function automatic int pix_total(input int width, input int height);
      return width * height;
   endfunction
   function automatic int flush_len(input int width, input int filt_width);
      return radius(filt_width) * width + radius(filt_width);
   endfunction
endpackage

// File: rtl/frame_stream_ctrl_if.sv
// frame_stream_if: control, memory, line-buffer and tagged-output signals of frame_stream_ctrl
// master: controller side (drives mem_rd/mem_addr, buf_en/buf_pix, out_*, busy, done)
// slave:  environment side (drives start, abort, mem_data, filt_valid, filt_pix)
interface frame_stream_if #(parameter int ADDR_W = 16);
   logic              start;
   logic              abort;
   logic              mem_rd;
   logic [ADDR_W-1:0] mem_addr;
   logic [7:0]        mem_data;
   logic              buf_en;
   logic [7:0]        buf_pix;
   logic              filt_valid;
   logic [7:0]        filt_pix;
   logic              out_valid;
   logic [7:0]        out_pix;
   logic              out_sof;
   logic              out_eol;
   logic              out_eof;
   logic              busy;
   logic              done;
   modport master (
      input  start, abort, mem_data, filt_valid, filt_pix,
      output mem_rd, mem_addr, buf_en, buf_pix, out_valid, out_pix, out_sof, out_eol, out_eof, busy, done
   );
   modport slave (
      output start, abort, mem_data, filt_valid, filt_pix,
      input  mem_rd, mem_addr, buf_en, buf_pix, out_valid, out_pix, out_sof, out_eol, out_eof, busy, done
   );
endinterface

// File: rtl/frame_stream_ctrl_raster_tagger.sv
// raster_tagger: counts kernel results in raster order and registers them with sof/eol/eof tags
// Ports: pixclk, rst (sync, active-high); clr clears counters and outputs (controller not running);
//        filt_valid/filt_pix in; out_valid/out_pix/out_sof/out_eol/out_eof out; full = frame count reached
// Macro BORDER_MASK_EN: zero out_pix for results within R of any image edge.
module raster_tagger
   import frame_ctrl_pkg::*;
#(
   parameter int WIDTH      = 256,
   parameter int HEIGHT     = 256,
   parameter int FILT_WIDTH = 3,
   parameter int ADDR_W     = 16
) (
   input  logic       pixclk,
   input  logic       rst,
   input  logic       clr,
   input  logic       filt_valid,
   input  logic [7:0] filt_pix,
   output logic       out_valid,
   output logic [7:0] out_pix,
   output logic       out_sof,
   output logic       out_eol,
   output logic       out_eof,
   output logic       full
);
   localparam int PT = pix_total(WIDTH, HEIGHT);
   localparam int R  = radius(FILT_WIDTH);
`ifdef BORDER_MASK_EN
   localparam bit MASK_EN = 1'b1;
`else
   localparam bit MASK_EN = 1'b0;
`endif
   logic [ADDR_W-1:0] col, row;
   logic [ADDR_W:0]   total;
   logic              acc, edge_px, last_col;
   assign full     = total == (ADDR_W+1)'(PT);
   assign acc      = filt_valid && !clr && !full;
   assign last_col = col == ADDR_W'(WIDTH-1);
   // Edge results see row wrap or flush padding inside their window.
   assign edge_px  = row < ADDR_W'(R) || row > ADDR_W'(HEIGHT-1-R) || col < ADDR_W'(R) || col > ADDR_W'(WIDTH-1-R);
   always_ff @(posedge pixclk) begin
      if (rst || clr) begin
         col       <= '0;
         row       <= '0;
         total     <= '0;
         out_valid <= 1'b0;
         out_pix   <= '0;
         out_sof   <= 1'b0;
         out_eol   <= 1'b0;
         out_eof   <= 1'b0;
      end else begin
         out_valid <= acc;
         out_pix   <= acc && !(MASK_EN && edge_px) ? filt_pix : '0;
         out_sof   <= acc && row == '0 && col == '0;
         out_eol   <= acc && last_col;
         out_eof   <= acc && total == (ADDR_W+1)'(PT-1);
         if (acc) begin
            col   <= last_col ? '0 : col + ADDR_W'(1);
            row   <= last_col ? row + ADDR_W'(1) : row;
            total <= total + (ADDR_W+1)'(1);
         end
      end
   end
endmodule

// File: rtl/frame_stream_ctrl.sv
// frame_stream_ctrl: sequences raster memory reads, line-buffer feed plus zero flush, and result tagging
// Ports: pixclk, rst (sync, active-high); bus (frame_stream_if.master): start/abort control,
//        mem_rd/mem_addr/mem_data memory, buf_en/buf_pix line buffer, filt_* kernel results,
//        out_* tagged results, busy/done status
// Macro BORDER_MASK_EN: enables edge masking of out_pix in raster_tagger.
module frame_stream_ctrl
   import frame_ctrl_pkg::*;
#(
   parameter int WIDTH      = 256,
   parameter int HEIGHT     = 256,
   parameter int FILT_WIDTH = 3,
   parameter int ADDR_W     = 16
) (
   input logic            pixclk,
   input logic            rst,
   frame_stream_if.master bus
);
   localparam int PT = pix_total(WIDTH, HEIGHT);
   localparam int FL = flush_len(WIDTH, FILT_WIDTH);
   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(PT-1);
   state_t            state, state_nx;
   logic [ADDR_W-1:0] fcnt;
   logic              rd_q, fl_q, run, full;
   always_ff @(posedge pixclk) begin
      if (rst) begin
         state        <= IDLE;
         bus.mem_addr <= '0;
         fcnt         <= '0;
         rd_q         <= 1'b0;
         fl_q         <= 1'b0;
      end else begin
         state        <= state_nx;
         bus.mem_addr <= bus.mem_rd && !bus.abort && bus.mem_addr != LAST ? bus.mem_addr + ADDR_W'(1) : '0;
         fcnt         <= state == FLUSH && !bus.abort ? fcnt + ADDR_W'(1) : '0;
         rd_q         <= bus.mem_rd && !bus.abort;
         fl_q         <= state == FLUSH && !bus.abort;
      end
   end
   always_comb begin
      state_nx = IDLE;
      case (state)
         IDLE:    state_nx = bus.start ? STREAM : IDLE;
         STREAM:  state_nx = bus.mem_addr == LAST ? FLUSH : STREAM;
         FLUSH:   state_nx = fcnt == ADDR_W'(FL-1) ? DRAIN : FLUSH;
         DRAIN:   state_nx = full ? DONE : DRAIN;
         default: state_nx = IDLE;
      endcase
      if (bus.abort) state_nx = IDLE;
      bus.mem_rd  = state == STREAM;
      bus.busy    = state != IDLE;
      bus.done    = state == DONE;
      // Memory data arrives one cycle after the read, so the registered strobe qualifies it.
      bus.buf_en  = rd_q || fl_q;
      bus.buf_pix = rd_q ? bus.mem_data : '0;
      run         = (state == STREAM || state == FLUSH || state == DRAIN) && !bus.abort;
   end
   raster_tagger #(
      .WIDTH(WIDTH), .HEIGHT(HEIGHT), .FILT_WIDTH(FILT_WIDTH), .ADDR_W(ADDR_W)
   ) u_tagger (
      .pixclk     (pixclk),
      .rst        (rst),
      .clr        (!run),
      .filt_valid (bus.filt_valid),
      .filt_pix   (bus.filt_pix),
      .out_valid  (bus.out_valid),
      .out_pix    (bus.out_pix),
      .out_sof    (bus.out_sof),
      .out_eol    (bus.out_eol),
      .out_eof    (bus.out_eof),
      .full       (full)
   );
endmodule

// File: tb/tb_frame_stream_ctrl.sv
// tb_frame_stream_ctrl: directed self-checking bench for frame_stream_ctrl (8x4 image, 3x3 kernel)
module tb_frame_stream_ctrl;
   localparam int W = 8, H = 4, FW = 3, AW = 16;
   logic pixclk = 1'b0;
   logic rst = 1'b1;
   int   n_chk = 0, n_err = 0;
   frame_stream_if #(.ADDR_W(AW)) bus();
   frame_stream_ctrl #(.WIDTH(W), .HEIGHT(H), .FILT_WIDTH(FW), .ADDR_W(AW)) dut (
      .pixclk (pixclk),
      .rst    (rst),
      .bus    (bus)
   );
   always #5 pixclk = ~pixclk;
   // Synchronous frame memory: data for an address appears one cycle after the read.
   always @(posedge pixclk) if (bus.mem_rd) bus.mem_data <= bus.mem_addr[7:0] ^ 8'hA5;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_chk++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, want);
      end
   endtask
   task automatic tick();
      @(posedge pixclk);
      #1;
   endtask
   task automatic check_idle_outputs(input string tag);
      check({tag, " mem_rd"}, bus.mem_rd, 0);
      check({tag, " mem_addr"}, bus.mem_addr, 0);
      check({tag, " buf_en"}, bus.buf_en, 0);
      check({tag, " buf_pix"}, bus.buf_pix, 0);
      check({tag, " out_valid"}, bus.out_valid, 0);
      check({tag, " out_pix"}, bus.out_pix, 0);
      check({tag, " tags"}, {bus.out_sof, bus.out_eol, bus.out_eof}, 0);
      check({tag, " busy"}, bus.busy, 0);
      check({tag, " done"}, bus.done, 0);
   endtask
   // Start was sampled on the first edge inside; k counts cycles after the start cycle.
   // filt_valid: 32 pulses with gaps over k=2..40, then a 33rd at k=41 once the count is full.
   task automatic frame(input bit ff, input bit hold);
      int         nf = 0;
      int         pj = -1;
      logic [7:0] px [32];
      logic [7:0] want_pix;
      for (int k = 1; k <= 44; k++) begin
         tick();
         if (!hold) bus.start = 1'b0;
         check($sformatf("mem_rd@%0d", k), bus.mem_rd, k <= 32);
         check($sformatf("mem_addr@%0d", k), bus.mem_addr, k <= 32 ? k - 1 : 0);
         check($sformatf("buf_en@%0d", k), bus.buf_en, k >= 2 && k <= 42);
         check($sformatf("buf_pix@%0d", k), bus.buf_pix, k >= 2 && k <= 33 ? ((k - 2) ^ 32'hA5) & 32'hFF : 0);
         check($sformatf("busy@%0d", k), bus.busy, k <= 43);
         check($sformatf("done@%0d", k), bus.done, k == 43);
         check($sformatf("out_valid@%0d", k), bus.out_valid, pj >= 0 && pj < 32);
         if (pj >= 0 && pj < 32) begin
            want_pix = px[pj];
`ifdef BORDER_MASK_EN
            if (pj / W < 1 || pj / W > H - 2 || pj % W < 1 || pj % W > W - 2) want_pix = 8'h00;
`endif
            check($sformatf("out_sof@%0d", pj), bus.out_sof, pj == 0);
            check($sformatf("out_eol@%0d", pj), bus.out_eol, pj % W == W - 1);
            check($sformatf("out_eof@%0d", pj), bus.out_eof, pj == 31);
            check($sformatf("out_pix@%0d", pj), bus.out_pix, want_pix);
         end
         if ((k >= 2 && k <= 40 && (k - 2) % 5 != 4) || k == 41) begin
            bus.filt_valid = 1'b1;
            bus.filt_pix   = ff ? 8'hFF : 8'(nf * 11 + 5);
            if (nf < 32) px[nf] = bus.filt_pix;
            pj = nf;
            nf++;
         end else begin
            bus.filt_valid = 1'b0;
            pj = -1;
         end
      end
   endtask
   initial begin
      bus.start      = 1'b0;
      bus.abort      = 1'b0;
      bus.filt_valid = 1'b0;
      bus.filt_pix   = 8'h00;
      repeat (3) tick();
      check_idle_outputs("reset");
      rst       = 1'b0;
      bus.start = 1'b1;
      frame(1'b0, 1'b0);
      // Back-to-back start right after done, held high through the whole frame.
      bus.start = 1'b1;
      frame(1'b1, 1'b1);
      frame(1'b1, 1'b0);
      // Abort in the fourth flush cycle.
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      repeat (34) tick();
      bus.filt_valid = 1'b1;
      bus.filt_pix   = 8'h42;
      tick();
      check("pre_abort out_valid", bus.out_valid, 1);
      check("pre_abort buf_en", bus.buf_en, 1);
      check("pre_abort busy", bus.busy, 1);
      bus.abort = 1'b1;
      tick();
      bus.abort      = 1'b0;
      bus.filt_valid = 1'b0;
      check_idle_outputs("abort");
      for (int i = 0; i < 4; i++) begin
         tick();
         check($sformatf("abort no done %0d", i), {bus.done, bus.busy}, 0);
      end
      // start and abort together in IDLE: abort wins.
      bus.start = 1'b1;
      bus.abort = 1'b1;
      tick();
      bus.abort = 1'b0;
      check("start+abort busy", bus.busy, 0);
      tick();
      bus.start = 1'b0;
      check("restart mem_rd", bus.mem_rd, 1);
      check("restart mem_addr", bus.mem_addr, 0);
      // Reset mid-stream at address 13, with start also requested.
      repeat (12) tick();
      bus.filt_valid = 1'b1;
      bus.filt_pix   = 8'h3C;
      tick();
      bus.filt_valid = 1'b0;
      check("pre_rst mem_addr", bus.mem_addr, 13);
      check("pre_rst out", {bus.out_valid, bus.out_sof, bus.out_pix}, {2'b11, 8'h3C});
      rst       = 1'b1;
      bus.start = 1'b1;
      tick();
      check_idle_outputs("mid_rst");
      rst       = 1'b0;
      bus.start = 1'b0;
      tick();
      check("post_rst busy", bus.busy, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
      $finish;
   end
endmodule
